// File: rtl/management_pkg.sv
// Shared types and defaults for the management UART transmit arbiter.
package management_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    // 100 us at 25 MHz without a byte from the owner revokes the grant.
    localparam int unsigned DEFAULT_STALL_TIMEOUT = 2500;

    // Width of one UART payload byte.
    localparam int unsigned BYTE_W = 8;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin pick: rotate the request vector past the previous owner and
// priority-encode the first set bit.
module rr_pick
    import management_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic                       found,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    // Scan upward from the slot after the previous owner, wrapping, first hit wins.
    always_comb begin
        logic [ID_W-1:0] cand;
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((32'(last) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ message sources with
// message-granular round-robin arbitration and a stall watchdog.
module uart_tx_arbiter
    import management_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned STALL_TIMEOUT = DEFAULT_STALL_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0]    req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx_en,
    output logic [BYTE_W-1:0]            tx_data,
    input  logic                         tx_done,
    output logic                         grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         abort
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(STALL_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STALL_TIMEOUT);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

    state_t             state;
    logic [ID_W-1:0]    last_grant;
    logic [CNT_W-1:0]   stall_cnt;
    logic               last_flag;

    logic               pick_found;
    logic [ID_W-1:0]    pick_idx;

    logic               cur_valid;
    logic               cur_last;
    logic [BYTE_W-1:0]  cur_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req   (req_valid),
        .last  (last_grant),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Select the current owner's byte, last flag and valid.
    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == grant_id) begin
                cur_valid = req_valid[i];
                cur_last  = req_last[i];
                cur_data  = req_data[BYTE_W*i +: BYTE_W];
            end
        end
    end

    // Only the owner sees ready, and only while the arbiter waits for its next byte.
    always_comb begin
        req_ready = '0;
        if (state == SEND) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                req_ready[i] = (ID_W'(i) == grant_id);
            end
        end
    end

    // Arbitration and byte-sequencing FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= ID_LAST;
            stall_cnt   <= '0;
            last_flag   <= 1'b0;
            tx_en       <= 1'b0;
            tx_data     <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            abort       <= 1'b0;
        end else begin
            tx_en <= 1'b0;
            abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id    <= pick_idx;
                        grant_valid <= 1'b1;
                        stall_cnt   <= '0;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (cur_valid) begin
                        tx_data   <= cur_data;
                        tx_en     <= 1'b1;
                        last_flag <= cur_last;
                        stall_cnt <= '0;
                        state     <= WAIT;
                    end else if (stall_cnt >= CNT_LAST) begin
                        // Owner went silent mid-message: revoke and pass the turn on.
                        abort       <= 1'b1;
                        grant_valid <= 1'b0;
                        last_grant  <= grant_id;
                        stall_cnt   <= '0;
                        state       <= IDLE;
                    end else if (stall_cnt != CNT_MAX) begin
                        stall_cnt <= stall_cnt + CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (tx_done) begin
                        if (last_flag) begin
                            grant_valid <= 1'b0;
                            last_grant  <= grant_id;
                            state       <= IDLE;
                        end else begin
                            state <= SEND;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-fed requesters, a delayed-done
// UART model, and one task per scenario with inline checks.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ       = 4;
    localparam int unsigned ID_W          = $clog2(NUM_REQ);
    localparam int unsigned STALL_TIMEOUT = 2500;
    localparam int unsigned UART_DELAY    = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_REQ-1:0]    req_valid;
    logic [8*NUM_REQ-1:0]  req_data;
    logic [NUM_REQ-1:0]    req_last;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  tx_en;
    logic [7:0]            tx_data;
    logic                  tx_done;
    logic                  grant_valid;
    logic [ID_W-1:0]       grant_id;
    logic                  abort;

    int unsigned cyc = 0;
    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [8:0]         src_q [NUM_REQ][$];
    logic [NUM_REQ-1:0] acc = '0;
    logic [7:0]         log_data [$];
    int unsigned        log_id [$];
    int unsigned        log_cyc [$];
    int unsigned        done_cyc [$];
    int unsigned        busy_cnt = 0;
    int unsigned        spur_req = 0;
    int unsigned        spur_ack = 0;

    uart_tx_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .STALL_TIMEOUT (STALL_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_en       (tx_en),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .abort       (abort)
    );

    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Requesters: present queue heads, pop after a handshake cycle.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i] && !rst && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = src_q[i][0][7:0];
                    req_last[i]        = src_q[i][0][8];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
                acc[i] = req_valid[i] && req_ready[i] && !rst;
            end
        end
    end

    // UART core model: log each tx_en, answer with tx_done UART_DELAY cycles later.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (rst) begin
                busy_cnt = 0;
            end else begin
                if (tx_en) begin
                    log_data.push_back(tx_data);
                    log_id.push_back(32'(grant_id));
                    log_cyc.push_back(cyc);
                    busy_cnt = UART_DELAY;
                end else if (busy_cnt > 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0) begin
                        tx_done = 1'b1;
                        done_cyc.push_back(cyc);
                    end
                end
                if (spur_req != spur_ack) begin
                    tx_done  = 1'b1;
                    spur_ack = spur_req;
                end
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: run still active at cycle %0d", cyc);
        $fatal(1, "bench did not complete");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        chk_cnt++; if (tx_en !== 1'b0) $display("FAIL reset_tx_en: got %b want 0", tx_en); else pass_cnt++;
        chk_cnt++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", tx_data); else pass_cnt++;
        chk_cnt++; if (grant_valid !== 1'b0) $display("FAIL reset_grant_valid: got %b want 0", grant_valid); else pass_cnt++;
        chk_cnt++; if (grant_id !== '0) $display("FAIL reset_grant_id: got %0d want 0", grant_id); else pass_cnt++;
        chk_cnt++; if (abort !== 1'b0) $display("FAIL reset_abort: got %b want 0", abort); else pass_cnt++;
        chk_cnt++; if (req_ready !== '0) $display("FAIL reset_req_ready: got %b want 0000", req_ready); else pass_cnt++;
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_spurious_done();
        int unsigned lbase;
        int bad;
        lbase = log_data.size();
        bad   = 0;
        spur_req++;
        repeat (8) begin
            tick();
            if (tx_en !== 1'b0 || grant_valid !== 1'b0 || req_ready !== '0) bad++;
        end
        chk_cnt++; if (bad != 0) $display("FAIL spurious_activity: got %0d active cycles want 0", bad); else pass_cnt++;
        chk_cnt++; if (log_data.size() != lbase) $display("FAIL spurious_tx: got %0d bytes want %0d", log_data.size(), lbase); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [7:0]  exp_b [4];
        int unsigned exp_i [4];
        int unsigned lbase, dbase;
        int k;
        logic [7:0]  got_b;
        int unsigned got_i;
        exp_b = '{8'hA0, 8'hA1, 8'hA2, 8'hB0};
        exp_i = '{0, 1, 2, 0};
        lbase = log_data.size();
        dbase = done_cyc.size();
        src_q[0].push_back({1'b1, 8'hA0});
        src_q[0].push_back({1'b1, 8'hB0});
        src_q[1].push_back({1'b1, 8'hA1});
        src_q[2].push_back({1'b1, 8'hA2});
        k = 0;
        while (done_cyc.size() < dbase + 4 && k < 500) begin tick(); k++; end
        chk_cnt++; if (k >= 500) $display("FAIL rr_timeout: got %0d dones want 4", done_cyc.size() - dbase); else pass_cnt++;
        for (int j = 0; j < 4; j++) begin
            got_b = (log_data.size() > lbase + j) ? log_data[lbase + j] : 8'h00;
            got_i = (log_id.size() > lbase + j) ? log_id[lbase + j] : 99;
            chk_cnt++; if (got_b !== exp_b[j]) $display("FAIL rr_byte%0d: got %h want %h", j, got_b, exp_b[j]); else pass_cnt++;
            chk_cnt++; if (got_i != exp_i[j]) $display("FAIL rr_id%0d: got %0d want %0d", j, got_i, exp_i[j]); else pass_cnt++;
        end
        repeat (3) tick();
    endtask

    task automatic test_single_hi();
        int unsigned lbase, dbase, t0;
        int k;
        logic gv_done, gv_after;
        logic [NUM_REQ-1:0] rdy;
        lbase = log_data.size();
        dbase = done_cyc.size();
        t0 = cyc;
        src_q[0].push_back({1'b0, 8'h48});
        src_q[0].push_back({1'b1, 8'h49});
        tick();
        tick();
        rdy = req_ready;
        chk_cnt++; if (rdy !== 4'b0001) $display("FAIL hi_ready_latency: got %b want 0001", rdy); else pass_cnt++;
        k = 0;
        while (done_cyc.size() < dbase + 2 && k < 200) begin tick(); k++; end
        chk_cnt++; if (k >= 200) $display("FAIL hi_timeout: got %0d dones want 2", done_cyc.size() - dbase); else pass_cnt++;
        gv_done = grant_valid;
        tick();
        gv_after = grant_valid;
        chk_cnt++; if (gv_done !== 1'b1) $display("FAIL hi_gv_at_done: got %b want 1", gv_done); else pass_cnt++;
        chk_cnt++; if (gv_after !== 1'b0) $display("FAIL hi_gv_after_done: got %b want 0", gv_after); else pass_cnt++;
        if (log_data.size() >= lbase + 2 && done_cyc.size() >= dbase + 2) begin
            chk_cnt++; if (log_data[lbase] !== 8'h48) $display("FAIL hi_byte0: got %h want 48", log_data[lbase]); else pass_cnt++;
            chk_cnt++; if (log_data[lbase+1] !== 8'h49) $display("FAIL hi_byte1: got %h want 49", log_data[lbase+1]); else pass_cnt++;
            chk_cnt++; if (log_cyc[lbase] != t0 + 3) $display("FAIL hi_first_tx_en: got cycle %0d want %0d", log_cyc[lbase], t0 + 3); else pass_cnt++;
            chk_cnt++; if (log_cyc[lbase+1] != done_cyc[dbase] + 2) $display("FAIL hi_gap: got cycle %0d want %0d", log_cyc[lbase+1], done_cyc[dbase] + 2); else pass_cnt++;
        end else begin
            chk_cnt++;
            $display("FAIL hi_bytes: got %0d bytes want 2", log_data.size() - lbase);
        end
        repeat (3) tick();
    endtask

    task automatic test_no_interleave();
        logic [7:0]  exp_b [4];
        int unsigned exp_i [4];
        int unsigned lbase, dbase;
        int k, early;
        logic [7:0]  got_b;
        int unsigned got_i;
        exp_b = '{8'hC1, 8'hC2, 8'hC3, 8'hD0};
        exp_i = '{1, 1, 1, 0};
        lbase = log_data.size();
        dbase = done_cyc.size();
        early = 0;
        src_q[1].push_back({1'b0, 8'hC1});
        src_q[1].push_back({1'b0, 8'hC2});
        src_q[1].push_back({1'b1, 8'hC3});
        src_q[0].push_back({1'b1, 8'hD0});
        k = 0;
        while (done_cyc.size() < dbase + 4 && k < 500) begin
            tick();
            k++;
            if (req_ready[0] === 1'b1 && done_cyc.size() < dbase + 3) early++;
        end
        chk_cnt++; if (k >= 500) $display("FAIL ni_timeout: got %0d dones want 4", done_cyc.size() - dbase); else pass_cnt++;
        chk_cnt++; if (early != 0) $display("FAIL ni_req0_ready_early: got %0d cycles want 0", early); else pass_cnt++;
        for (int j = 0; j < 4; j++) begin
            got_b = (log_data.size() > lbase + j) ? log_data[lbase + j] : 8'h00;
            got_i = (log_id.size() > lbase + j) ? log_id[lbase + j] : 99;
            chk_cnt++; if (got_b !== exp_b[j]) $display("FAIL ni_byte%0d: got %h want %h", j, got_b, exp_b[j]); else pass_cnt++;
            chk_cnt++; if (got_i != exp_i[j]) $display("FAIL ni_id%0d: got %0d want %0d", j, got_i, exp_i[j]); else pass_cnt++;
        end
        repeat (3) tick();
    endtask

    task automatic test_stall_abort();
        int unsigned lbase, dbase, dc, abort_cyc;
        int k, abort_cnt;
        logic gv_at_abort;
        logic [NUM_REQ-1:0] rdy_at_abort;
        lbase = log_data.size();
        dbase = done_cyc.size();
        abort_cnt = 0;
        abort_cyc = 0;
        gv_at_abort = 1'b1;
        rdy_at_abort = '1;
        src_q[2].push_back({1'b0, 8'hE0});
        src_q[3].push_back({1'b1, 8'hF0});
        k = 0;
        while (done_cyc.size() < dbase + 2 && k < STALL_TIMEOUT + 200) begin
            tick();
            k++;
            if (abort === 1'b1) begin
                abort_cnt++;
                abort_cyc    = cyc;
                gv_at_abort  = grant_valid;
                rdy_at_abort = req_ready;
            end
        end
        chk_cnt++; if (k >= STALL_TIMEOUT + 200) $display("FAIL stall_timeout: got %0d dones want 2", done_cyc.size() - dbase); else pass_cnt++;
        dc = (done_cyc.size() > dbase) ? done_cyc[dbase] : 0;
        chk_cnt++; if (abort_cnt != 1) $display("FAIL stall_abort_count: got %0d want 1", abort_cnt); else pass_cnt++;
        chk_cnt++; if (abort_cyc != dc + 1 + STALL_TIMEOUT) $display("FAIL stall_abort_cycle: got %0d want %0d", abort_cyc, dc + 1 + STALL_TIMEOUT); else pass_cnt++;
        chk_cnt++; if (gv_at_abort !== 1'b0) $display("FAIL stall_gv_at_abort: got %b want 0", gv_at_abort); else pass_cnt++;
        chk_cnt++; if (rdy_at_abort !== '0) $display("FAIL stall_ready_at_abort: got %b want 0000", rdy_at_abort); else pass_cnt++;
        chk_cnt++; if (log_data.size() != lbase + 2) $display("FAIL stall_bytes: got %0d want 2", log_data.size() - lbase);
        else begin
            pass_cnt++;
            chk_cnt++; if (log_data[lbase] !== 8'hE0) $display("FAIL stall_byte0: got %h want e0", log_data[lbase]); else pass_cnt++;
            chk_cnt++; if (log_id[lbase+1] != 3) $display("FAIL stall_next_owner: got %0d want 3", log_id[lbase+1]); else pass_cnt++;
            chk_cnt++; if (log_data[lbase+1] !== 8'hF0) $display("FAIL stall_byte1: got %h want f0", log_data[lbase+1]); else pass_cnt++;
        end
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_message();
        int unsigned lbase, dbase;
        int k;
        logic [7:0]  got_b;
        int unsigned got_i;
        dbase = done_cyc.size();
        src_q[1].push_back({1'b1, 8'h51});
        k = 0;
        while (done_cyc.size() < dbase + 1 && k < 200) begin tick(); k++; end
        repeat (3) tick();
        lbase = log_data.size();
        src_q[1].push_back({1'b0, 8'h60});
        src_q[1].push_back({1'b1, 8'h61});
        k = 0;
        while (log_data.size() < lbase + 1 && k < 200) begin tick(); k++; end
        chk_cnt++; if (tx_en !== 1'b1) $display("FAIL rm_tx_en_before: got %b want 1", tx_en); else pass_cnt++;
        rst = 1'b1;
        #1;
        chk_cnt++; if (tx_en !== 1'b0) $display("FAIL rm_tx_en: got %b want 0", tx_en); else pass_cnt++;
        chk_cnt++; if (tx_data !== 8'h00) $display("FAIL rm_tx_data: got %h want 00", tx_data); else pass_cnt++;
        chk_cnt++; if (grant_valid !== 1'b0) $display("FAIL rm_grant_valid: got %b want 0", grant_valid); else pass_cnt++;
        chk_cnt++; if (grant_id !== '0) $display("FAIL rm_grant_id: got %0d want 0", grant_id); else pass_cnt++;
        chk_cnt++; if (abort !== 1'b0) $display("FAIL rm_abort: got %b want 0", abort); else pass_cnt++;
        chk_cnt++; if (req_ready !== '0) $display("FAIL rm_req_ready: got %b want 0000", req_ready); else pass_cnt++;
        for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        lbase = log_data.size();
        dbase = done_cyc.size();
        src_q[0].push_back({1'b1, 8'h70});
        src_q[2].push_back({1'b1, 8'h72});
        k = 0;
        while (done_cyc.size() < dbase + 2 && k < 200) begin tick(); k++; end
        chk_cnt++; if (k >= 200) $display("FAIL rm_timeout: got %0d dones want 2", done_cyc.size() - dbase); else pass_cnt++;
        got_b = (log_data.size() > lbase) ? log_data[lbase] : 8'h00;
        got_i = (log_id.size() > lbase) ? log_id[lbase] : 99;
        chk_cnt++; if (got_i != 0) $display("FAIL rm_first_owner: got %0d want 0", got_i); else pass_cnt++;
        chk_cnt++; if (got_b !== 8'h70) $display("FAIL rm_first_byte: got %h want 70", got_b); else pass_cnt++;
        got_b = (log_data.size() > lbase + 1) ? log_data[lbase + 1] : 8'h00;
        chk_cnt++; if (got_b !== 8'h72) $display("FAIL rm_second_byte: got %h want 72", got_b); else pass_cnt++;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_spurious_done();
        test_round_robin();
        test_single_hi();
        test_no_interleave();
        test_stall_abort();
        test_reset_mid_message();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
